// File: rtl/mem_fill_arbiter_pkg.sv
// Shared types and constants for the memory fill arbiter: FSM states,
// cache owner encoding and block geometry.
package mem_fill_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } owner_e;

    localparam int BLOCK_WORDS = 8;
    localparam int OFFSET_W    = 4;
    localparam int WORD_IDX_W  = 3;

endpackage

// File: rtl/mem_fill_arbiter_miss_arb_rr.sv
// Two-way round-robin grant between icache and dcache misses; a tie goes
// to the side that was not granted last.
module miss_arb_rr
    import mem_fill_arbiter_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_e last_grant,
    output logic   grant_valid,
    output owner_e grant
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant       = ICACHE;
        if (d_req && !i_req) begin
            grant = DCACHE;
        end else if (d_req && i_req) begin
            grant = (last_grant == ICACHE) ? DCACHE : ICACHE;
        end
    end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Memory-side controller shared by icache and dcache: serves write-through
// stores and block fills, streaming returned words into the owner's arrays.
module mem_fill_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LAT     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_miss,
    input  logic [ADDR_W-1:0]              i_miss_addr,
    input  logic                           d_miss,
    input  logic [ADDR_W-1:0]              d_miss_addr,
    input  logic                           d_wr,
    input  logic [ADDR_W-1:0]              d_wr_addr,
    input  logic [DATA_W-1:0]              d_wr_data,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    input  logic                           mem_rvalid,
    output logic [DATA_W-1:0]              fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic                           fill_we_i,
    output logic                           fill_we_d,
    output logic                           tag_we_i,
    output logic                           tag_we_d,
    output logic                           i_done,
    output logic                           d_done,
    output logic                           wr_ack
);
    import mem_fill_arbiter_pkg::*;

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0]   ret_cnt_q, ret_cnt_d;
    owner_e             last_grant_q, last_grant_d;
    owner_e             owner_q, owner_d;
    logic [ADDR_W-1:0]  base_q, base_d;

    logic               grant_valid;
    owner_e             grant;
    logic [ADDR_W-OFF_W-1:0] miss_blk;

    // Byte offset within the block never matters: fills always start aligned.
    logic unused_bits;
    assign unused_bits = ^{i_miss_addr[OFF_W-1:0], d_miss_addr[OFF_W-1:0]} ^ (MEM_LAT > 0);

    miss_arb_rr u_arb (
        .i_req       (i_miss),
        .d_req       (d_miss),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign miss_blk = (grant == DCACHE) ? d_miss_addr[ADDR_W-1:OFF_W]
                                        : i_miss_addr[ADDR_W-1:OFF_W];

    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        base_d       = base_q;

        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_data = '0;
        fill_word = '0;
        fill_we_i = 1'b0;
        fill_we_d = 1'b0;
        tag_we_i  = 1'b0;
        tag_we_d  = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        wr_ack    = 1'b0;

        case (state_q)
            IDLE: begin
                // Stores go first so the dcache write buffer never backs up behind fills.
                if (d_wr) begin
                    state_d = WRITE;
                end else if (grant_valid) begin
                    base_d       = {miss_blk, {OFF_W{1'b0}}};
                    owner_d      = grant;
                    last_grant_d = grant;
                    state_d      = REQ;
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_wr_addr;
                mem_wdata = d_wr_data;
                wr_ack    = 1'b1;
                state_d   = IDLE;
            end
            REQ: begin
                mem_en      = 1'b1;
                mem_addr    = base_q + ADDR_W'({issue_cnt_q, 1'b0});
                issue_cnt_d = issue_cnt_q + 1'b1;
                if (issue_cnt_q == LAST_IDX) begin
                    issue_cnt_d = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
            end
            DONE: begin
                i_done  = (owner_q == ICACHE);
                d_done  = (owner_q == DCACHE);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Returned words may overlap the tail of the issue phase.
        if ((state_q == REQ || state_q == WAIT) && mem_rvalid) begin
            fill_data = mem_rdata;
            fill_word = ret_cnt_q;
            fill_we_i = (owner_q == ICACHE);
            fill_we_d = (owner_q == DCACHE);
            ret_cnt_d = ret_cnt_q + 1'b1;
            if (ret_cnt_q == LAST_IDX) begin
                tag_we_i  = (owner_q == ICACHE);
                tag_we_d  = (owner_q == DCACHE);
                ret_cnt_d = '0;
                state_d   = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            issue_cnt_q  <= '0;
            ret_cnt_q    <= '0;
            last_grant_q <= ICACHE;
            owner_q      <= ICACHE;
            base_q       <= '0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            base_q       <= base_d;
        end
    end

endmodule
